// File: rtl/banco_reg_pkg.sv
`default_nettype none
// ============================================================================
// banco_reg_pkg : shared CPU constants for the register file.
// Revision 1.0
// ============================================================================
package banco_reg_pkg;

   localparam int CPU_DATA_W = 32;
   localparam int CPU_ADDR_W = 5;
   localparam int CPU_SP_IDX = 29;
   localparam int CPU_SP_RST = 227;

endpackage : banco_reg_pkg
`default_nettype wire

// File: rtl/banco_reg.sv
`default_nettype none
// ============================================================================
// banco_reg : 32-entry register file, two combinational read ports, one write
//             port, asynchronous reset that preloads the stack pointer.
// Revision 1.0
// ============================================================================
module banco_reg
   import banco_reg_pkg::*;
#(
   parameter int                DATA_W = CPU_DATA_W,
   parameter int                ADDR_W = CPU_ADDR_W,
   parameter int                SP_IDX = CPU_SP_IDX,
   parameter logic [DATA_W-1:0] SP_RST = DATA_W'(CPU_SP_RST)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
);

   localparam int N_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [N_REGS];
   logic [DATA_W-1:0] regs_d [N_REGS];

   always_comb begin
      regs_d = regs_q;
      // Index 0 is hardwired to zero, so writes there are dropped.
      if (RegWrite && (WriteReg != '0)) begin
         regs_d[WriteReg] = WriteData;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < N_REGS; i++) begin
            regs_q[i] <= (i == SP_IDX) ? SP_RST : '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign ReadData1 = (ReadReg1 == '0) ? '0 : regs_q[ReadReg1];
   assign ReadData2 = (ReadReg2 == '0) ? '0 : regs_q[ReadReg2];

endmodule : banco_reg
`default_nettype wire

// File: tb/tb_banco_reg.sv
`default_nettype none
// ============================================================================
// tb_banco_reg : directed self-checking bench for banco_reg.
// Revision 1.0
// ============================================================================
module tb_banco_reg;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        RegWrite;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;

   int n_checks = 0;
   int n_errors = 0;

   banco_reg dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .RegWrite  (RegWrite),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2)
   );

   always #5 Clk = ~Clk;

   // Drive a write away from the edge, let it land, then drop RegWrite.
   task automatic do_write(input logic [4:0] idx, input logic [31:0] val);
      @(negedge Clk);
      WriteReg  = idx;
      WriteData = val;
      RegWrite  = 1'b1;
      @(posedge Clk);
      #1;
      RegWrite  = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] exp;
      @(negedge Clk);
      #2 Reset = 1'b1;
      #1 Reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         exp = (i == 29) ? 32'd227 : 32'd0;
         ReadReg1 = 5'(i);
         ReadReg2 = 5'(31 - i);
         #1;
         n_checks++;
         if (ReadData1 !== exp) begin
            n_errors++;
            $display("FAIL reset_rd1 idx=%0d got=%h exp=%h", i, ReadData1, exp);
         end
         exp = ((31 - i) == 29) ? 32'd227 : 32'd0;
         n_checks++;
         if (ReadData2 !== exp) begin
            n_errors++;
            $display("FAIL reset_rd2 idx=%0d got=%h exp=%h", 31 - i, ReadData2, exp);
         end
      end
   endtask

   task automatic test_write_read;
      do_write(5'd5, 32'hDEADBEEF);
      ReadReg1 = 5'd5;
      ReadReg2 = 5'd5;
      #1;
      n_checks++;
      if (ReadData1 !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL wr_r5_rd1 got=%h exp=%h", ReadData1, 32'hDEADBEEF);
      end
      n_checks++;
      if (ReadData2 !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL wr_r5_rd2 got=%h exp=%h", ReadData2, 32'hDEADBEEF);
      end
      ReadReg1 = 5'd4;
      ReadReg2 = 5'd6;
      #1;
      n_checks++;
      if (ReadData1 !== 32'h0) begin
         n_errors++;
         $display("FAIL wr_r4_untouched got=%h exp=%h", ReadData1, 32'h0);
      end
      n_checks++;
      if (ReadData2 !== 32'h0) begin
         n_errors++;
         $display("FAIL wr_r6_untouched got=%h exp=%h", ReadData2, 32'h0);
      end
   endtask

   task automatic test_r0;
      do_write(5'd0, 32'h12345678);
      ReadReg1 = 5'd0;
      ReadReg2 = 5'd0;
      #1;
      n_checks++;
      if (ReadData1 !== 32'h0) begin
         n_errors++;
         $display("FAIL r0_rd1 got=%h exp=%h", ReadData1, 32'h0);
      end
      n_checks++;
      if (ReadData2 !== 32'h0) begin
         n_errors++;
         $display("FAIL r0_rd2 got=%h exp=%h", ReadData2, 32'h0);
      end
   endtask

   task automatic test_write_timing;
      @(negedge Clk);
      WriteReg  = 5'd7;
      WriteData = 32'hA5A5A5A5;
      RegWrite  = 1'b1;
      ReadReg1  = 5'd7;
      #1;
      n_checks++;
      if (ReadData1 !== 32'h0) begin
         n_errors++;
         $display("FAIL timing_before_edge got=%h exp=%h", ReadData1, 32'h0);
      end
      @(posedge Clk);
      #1;
      RegWrite = 1'b0;
      n_checks++;
      if (ReadData1 !== 32'hA5A5A5A5) begin
         n_errors++;
         $display("FAIL timing_after_edge got=%h exp=%h", ReadData1, 32'hA5A5A5A5);
      end
      // Same stimulus with enable low must leave r7 alone.
      @(negedge Clk);
      WriteData = 32'h5A5A5A5A;
      RegWrite  = 1'b0;
      @(posedge Clk);
      #1;
      n_checks++;
      if (ReadData1 !== 32'hA5A5A5A5) begin
         n_errors++;
         $display("FAIL timing_we_low got=%h exp=%h", ReadData1, 32'hA5A5A5A5);
      end
   endtask

   task automatic test_back_to_back;
      @(negedge Clk);
      RegWrite  = 1'b1;
      WriteReg  = 5'd10;
      WriteData = 32'h0000_000A;
      @(negedge Clk);
      WriteReg  = 5'd11;
      WriteData = 32'h8000_0001;
      @(negedge Clk);
      WriteReg  = 5'd12;
      WriteData = 32'hFFFF_0000;
      @(negedge Clk);
      RegWrite  = 1'b0;
      ReadReg1  = 5'd10;
      ReadReg2  = 5'd11;
      #1;
      n_checks++;
      if (ReadData1 !== 32'h0000_000A) begin
         n_errors++;
         $display("FAIL b2b_r10 got=%h exp=%h", ReadData1, 32'h0000_000A);
      end
      n_checks++;
      if (ReadData2 !== 32'h8000_0001) begin
         n_errors++;
         $display("FAIL b2b_r11 got=%h exp=%h", ReadData2, 32'h8000_0001);
      end
      ReadReg1 = 5'd12;
      ReadReg2 = 5'd13;
      #1;
      n_checks++;
      if (ReadData1 !== 32'hFFFF_0000) begin
         n_errors++;
         $display("FAIL b2b_r12 got=%h exp=%h", ReadData1, 32'hFFFF_0000);
      end
      n_checks++;
      if (ReadData2 !== 32'h0) begin
         n_errors++;
         $display("FAIL b2b_r13_untouched got=%h exp=%h", ReadData2, 32'h0);
      end
   endtask

   task automatic test_async_reset;
      do_write(5'd31, 32'hFFFFFFFF);
      do_write(5'd29, 32'h00000100);
      ReadReg1 = 5'd31;
      ReadReg2 = 5'd29;
      #1;
      n_checks++;
      if (ReadData1 !== 32'hFFFFFFFF) begin
         n_errors++;
         $display("FAIL sp_pre_r31 got=%h exp=%h", ReadData1, 32'hFFFFFFFF);
      end
      n_checks++;
      if (ReadData2 !== 32'h00000100) begin
         n_errors++;
         $display("FAIL sp_write_r29 got=%h exp=%h", ReadData2, 32'h00000100);
      end
      @(negedge Clk);
      #1 Reset = 1'b1;
      #1;
      n_checks++;
      if (ReadData1 !== 32'h0) begin
         n_errors++;
         $display("FAIL async_rst_r31 got=%h exp=%h", ReadData1, 32'h0);
      end
      n_checks++;
      if (ReadData2 !== 32'd227) begin
         n_errors++;
         $display("FAIL async_rst_r29 got=%h exp=%h", ReadData2, 32'd227);
      end
      #1 Reset = 1'b0;
   endtask

   task automatic test_reset_priority;
      do_write(5'd3, 32'h0000_1111);
      @(negedge Clk);
      Reset     = 1'b1;
      RegWrite  = 1'b1;
      WriteReg  = 5'd3;
      WriteData = 32'h0000_0055;
      @(posedge Clk);
      #1;
      RegWrite = 1'b0;
      Reset    = 1'b0;
      ReadReg1 = 5'd3;
      #1;
      n_checks++;
      if (ReadData1 !== 32'h0) begin
         n_errors++;
         $display("FAIL rst_priority_r3 got=%h exp=%h", ReadData1, 32'h0);
      end
      // First edge after release must accept a write.
      do_write(5'd3, 32'h0000_0055);
      #1;
      n_checks++;
      if (ReadData1 !== 32'h0000_0055) begin
         n_errors++;
         $display("FAIL first_write_after_rst got=%h exp=%h", ReadData1, 32'h0000_0055);
      end
   endtask

   initial begin
      Reset     = 1'b0;
      RegWrite  = 1'b0;
      ReadReg1  = '0;
      ReadReg2  = '0;
      WriteReg  = '0;
      WriteData = '0;
      test_reset();
      test_write_read();
      test_r0();
      test_write_timing();
      test_back_to_back();
      test_async_reset();
      test_reset_priority();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_banco_reg
`default_nettype wire
